decode_stage: RTL and testbench

- Registered, handshaked RV32I decode stage: accepts fetched instructions, produces a registered control word, and inserts load-use bubbles.
- Parametrised successor to the combinational control decoder, with a wider/encoded control word, illegal-instruction detection, flush and backpressure.
- Sits between the fetch (IF) and execute (EX) stages of the pipelined core.

---
 rtl/decode_stage.sv | 211 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with load-use bubble insertion, flush and backpressure.
// Optional macro DECODE_CSR_EN enables CSRRW/CSRRWI decode; without it those encodings are illegal.
module decode_stage #(
  parameter int PC_W     = 32,
  parameter int CTRL_W   = 16,
  parameter int LU_STALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [2:0]        out_funct3,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [PC_W-1:0]   out_pc,
  output logic [31:0]       out_inst,
  output logic              out_illegal,
  output logic              out_csr
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`ifdef DECODE_CSR_EN
  localparam logic [6:0] OP_SYS    = 7'b1110011;
`endif

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10;

  localparam logic [2:0] IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign rd     = in_inst[11:7];
  assign rs1    = in_inst[19:15];
  assign rs2    = in_inst[24:20];

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  logic rd_wen, mem_wr, mem_rd, branch, jal, jalr, a_sel_pc, b_sel_imm, wb_pc4;
  logic [3:0] alu_op;
  logic [2:0] imm_type;
  logic illegal, is_csr, is_load, use_rs1, use_rs2;
  logic [15:0] ctrl16;

  always_comb begin
    rd_wen = 1'b0; mem_wr = 1'b0; mem_rd = 1'b0; branch = 1'b0;
    jal = 1'b0; jalr = 1'b0; a_sel_pc = 1'b0; b_sel_imm = 1'b0; wb_pc4 = 1'b0;
    alu_op = ALU_ADD; imm_type = IMM_NONE;
    illegal = 1'b0; is_csr = 1'b0; is_load = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        rd_wen = 1'b1; alu_op = alu_of(funct3, in_inst[30]);
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_I: begin
        rd_wen = 1'b1; b_sel_imm = 1'b1; imm_type = IMM_I; use_rs1 = 1'b1;
        alu_op = alu_of(funct3, in_inst[30] && (funct3 == 3'b101));
      end
      OP_LOAD: begin
        rd_wen = 1'b1; mem_rd = 1'b1; b_sel_imm = 1'b1; imm_type = IMM_I;
        use_rs1 = 1'b1; is_load = 1'b1;
      end
      OP_STORE: begin
        mem_wr = 1'b1; b_sel_imm = 1'b1; imm_type = IMM_S;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
        else begin
          branch = 1'b1; a_sel_pc = 1'b1; b_sel_imm = 1'b1; imm_type = IMM_B;
          use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
      end
      OP_LUI: begin
        rd_wen = 1'b1; b_sel_imm = 1'b1; alu_op = ALU_PASS_B; imm_type = IMM_U;
      end
      OP_AUIPC: begin
        rd_wen = 1'b1; a_sel_pc = 1'b1; b_sel_imm = 1'b1; imm_type = IMM_U;
      end
      OP_JAL: begin
        rd_wen = 1'b1; jal = 1'b1; a_sel_pc = 1'b1; b_sel_imm = 1'b1;
        imm_type = IMM_J; wb_pc4 = 1'b1;
      end
      OP_JALR: begin
        rd_wen = 1'b1; jalr = 1'b1; b_sel_imm = 1'b1; imm_type = IMM_I;
        wb_pc4 = 1'b1; use_rs1 = 1'b1;
      end
`ifdef DECODE_CSR_EN
      // Only CSRRW/CSRRWI are supported; the CSR value reaches rd through PASS_B.
      OP_SYS: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          rd_wen = 1'b1; alu_op = ALU_PASS_B; imm_type = IMM_I; is_csr = 1'b1;
          use_rs1 = (funct3 == 3'b001);
        end else illegal = 1'b1;
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

  assign ctrl16 = illegal ? 16'h0000 :
    {wb_pc4, imm_type, alu_op, b_sel_imm, a_sel_pc, jalr, jal, branch, mem_rd, mem_wr, rd_wen};

  // Handshake: input transfers on in_valid & in_ready; output transfers on out_valid & out_ready;
  // the output register may only change when it is empty or being consumed (advance).
  logic advance, hazard, fire;
  assign advance  = !out_valid || out_ready;
  assign in_ready = flush || (advance && !hazard);
  assign fire     = in_valid && in_ready && !flush;

  generate
    if (LU_STALL > 0) begin : g_hist
      logic       hist_load [LU_STALL];
      logic [4:0] hist_rd   [LU_STALL];
      logic       hit;
      logic       push_load;

      assign push_load = fire && is_load && (rd != 5'd0);

      always_comb begin
        hit = 1'b0;
        for (int i = 0; i < LU_STALL; i++) begin
          if (hist_load[i] && ((use_rs1 && rs1 != 5'd0 && rs1 == hist_rd[i]) ||
                               (use_rs2 && rs2 != 5'd0 && rs2 == hist_rd[i])))
            hit = 1'b1;
        end
      end

      assign hazard = in_valid && hit;

      always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
          for (int i = 0; i < LU_STALL; i++) begin
            hist_load[i] <= 1'b0;
            hist_rd[i]   <= 5'd0;
          end
        end else if (advance) begin
          hist_load[0] <= push_load;
          hist_rd[0]   <= push_load ? rd : 5'd0;
          for (int i = 1; i < LU_STALL; i++) begin
            hist_load[i] <= hist_load[i-1];
            hist_rd[i]   <= hist_rd[i-1];
          end
        end
      end
    end else begin : g_no_hist
      assign hazard = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_ctrl    <= '0;
      out_funct3  <= 3'd0;
      out_rd      <= 5'd0;
      out_rs1     <= 5'd0;
      out_rs2     <= 5'd0;
      out_pc      <= '0;
      out_inst    <= 32'd0;
      out_illegal <= 1'b0;
      out_csr     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid   <= 1'b1;
      out_ctrl    <= CTRL_W'(ctrl16);
      out_funct3  <= funct3;
      out_rd      <= rd;
      out_rs1     <= rs1;
      out_rs2     <= rs2;
      out_pc      <= in_pc;
      out_inst    <= in_inst;
      out_illegal <= illegal;
      out_csr     <= is_csr;
    end else if (advance) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors, expected entries queued at issue, checked by a monitor.
module tb_decode_stage;
  localparam int PC_W   = 32;
  localparam int CTRL_W = 16;
  localparam int EW     = 100;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal, out_csr;
  logic [31:0]       in_inst, out_inst;
  logic [PC_W-1:0]   in_pc, out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic [2:0]        out_funct3;
  logic [4:0]        out_rd, out_rs1, out_rs2;

  int total = 0, bad = 0, pops = 0, gap = 0, last_gap = 0, st = 0;
  logic [31:0]   pc_ctr = 32'h0000_0100;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] act_v;

  decode_stage #(.PC_W(PC_W), .CTRL_W(CTRL_W), .LU_STALL(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_funct3(out_funct3), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_pc(out_pc), .out_inst(out_inst), .out_illegal(out_illegal), .out_csr(out_csr)
  );

  always #5 clk = ~clk;

  assign act_v = {out_csr, out_illegal, out_ctrl, out_rd, out_rs1, out_rs2, out_funct3, out_pc, out_inst};

  function automatic logic [EW-1:0] mk_exp(input logic [31:0] inst, input logic [31:0] pc,
                                           input logic [15:0] ctrl, input logic ill, input logic csr);
    mk_exp = {csr, ill, ctrl, inst[11:7], inst[19:15], inst[24:20], inst[14:12], pc, inst};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one instruction until accepted; the expected entry is queued at the accepting cycle.
  task automatic send(input string name, input logic [31:0] inst, input logic [15:0] ctrl,
                      input logic ill, input logic csr, output int stalls);
    int  n    = 0;
    bit  done = 1'b0;
    stalls   = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc_ctr;
    while (!done && n < 20) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(mk_exp(inst, pc_ctr, ctrl, ill, csr));
        done = 1'b1;
      end else stalls++;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    pc_ctr   = pc_ctr + 32'd4;
    if (!done) begin
      total++; bad++;
      $display("FAIL %s: not accepted within 20 cycles", name);
    end
  endtask

  task automatic wait_pops(input int n);
    int k = 0;
    while (pops < n && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (pops < n) begin
      total++; bad++;
      $display("FAIL wait_pops: got %0d outputs expected %0d", pops, n);
    end
  endtask

  // Monitor: every transferred output entry is compared against the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        pops++;
        last_gap = gap;
        gap = 0;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got %h expected none", act_v);
        end else check("output entry", act_v, exp_q.pop_front());
      end else if (!out_valid) gap++;
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_pc = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_ctrl", out_ctrl, 0);
    check("reset in_ready", in_ready, 1);
    @(posedge clk); #1;

    send("add", 32'h002081B3, 16'h0001, 1'b0, 1'b0, st);
    wait_pops(1);

    // Dependent load-use pair: one stall cycle and one bubble.
    send("lw", 32'h0000A283, 16'h1085, 1'b0, 1'b0, st);
    send("add_dep", 32'h00028333, 16'h0001, 1'b0, 1'b0, st);
    check("dep stall cycles", st, 1);
    wait_pops(3);
    check("dep bubble", last_gap, 1);

    send("lw2", 32'h0000A283, 16'h1085, 1'b0, 1'b0, st);
    send("add_nodep", 32'h00000333, 16'h0001, 1'b0, 1'b0, st);
    check("nodep stall cycles", st, 0);
    wait_pops(5);
    check("nodep bubble", last_gap, 0);

    // Backpressure: entry must hold bit-for-bit while out_ready is low.
    out_ready = 1'b0;
    send("sub", 32'h402083B3, 16'h0101, 1'b0, 1'b0, st);
    in_valid = 1'b1; in_inst = 32'h4033D413; in_pc = pc_ctr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold in_ready", in_ready, 0);
      check("hold out_valid", out_valid, 1);
      check("hold entry", act_v, mk_exp(32'h402083B3, pc_ctr - 32'd4, 16'h0101, 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send("srai", 32'h4033D413, 16'h1781, 1'b0, 1'b0, st);
    check("release stall", st, 0);
    wait_pops(7);
    check("release gap", last_gap, 0);

    // Flush while stalled by out_ready: kills the load and its history entry.
    out_ready = 1'b0;
    send("lw_flush", 32'h0000A283, 16'h1085, 1'b0, 1'b0, st);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00028333; in_pc = pc_ctr;
    @(negedge clk);
    check("flush in_ready", in_ready, 1);
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    void'(exp_q.pop_back());
    check("flush out_valid", out_valid, 0);
    send("add_after_flush", 32'h00028333, 16'h0001, 1'b0, 1'b0, st);
    check("flush no stall", st, 0);
    wait_pops(8);

    send("illegal_op", 32'h0000007F, 16'h0000, 1'b1, 1'b0, st);
    send("illegal_branch", 32'h00002063, 16'h0000, 1'b1, 1'b0, st);
    send("sw", 32'h0020A223, 16'h2082, 1'b0, 1'b0, st);
`ifdef DECODE_CSR_EN
    send("csrrw", 32'h300110F3, 16'h1A01, 1'b0, 1'b1, st);
`else
    send("csrrw", 32'h300110F3, 16'h0000, 1'b1, 1'b0, st);
`endif
    wait_pops(12);
    repeat (2) @(posedge clk);
    check("queue drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
